// File: rtl/uart_tx_arb_pkg.sv
// Purpose: shared FSM state type and header-byte helper for uart_tx_arb.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package uart_tx_arb_pkg;

   // Hdr exists only when the per-frame ID header is compiled in.
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
`ifdef UART_TX_ARB_ID_HDR_EN
      S_HDR       = 3'd2,
`endif
      S_WAIT_DONE = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   localparam logic [3:0] ID_HDR_NIBBLE = 4'hA;

   // Header byte announcing which requester owns the frame that follows.
   function automatic logic [7:0] hdr_byte(input logic [3:0] id);
      return {ID_HDR_NIBBLE, id};
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Purpose: combinational round-robin picker, first set request above i_ptr (wrapping).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [W-1:0]       i_ptr,
   output logic               o_valid,
   output logic [W-1:0]       o_idx
);

   // Scan i_ptr+1 .. i_ptr+NUM_REQ (mod NUM_REQ); the first hit wins, so i_ptr itself is last.
   always_comb begin
      int c;
      c       = 0;
      o_valid = 1'b0;
      o_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         c = int'(i_ptr) + i;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!o_valid && i_req[c]) begin
            o_valid = 1'b1;
            o_idx   = c[W-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Purpose: round-robin share of one UART_Tx among NUM_REQ framed byte streams (optional ID header: UART_TX_ARB_ID_HDR_EN).
// Latency: req_valid in Idle -> u_data_en after 2 clocks; one byte in flight at a time.
// Backpressure: req_ready only toward the granted requester in Load; next byte waits for tx_done to rise and fall.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_last,
   input  logic [NUM_REQ*8-1:0]       req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       u_data_en,
   output logic [7:0]                 u_data,
   input  logic                       u_tx_done,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int W = $clog2(NUM_REQ);

   state_t            r_state;
   logic [W-1:0]      r_ptr;
   logic [W-1:0]      r_grant_id;
   logic              r_locked;
   logic              r_data_en;
   logic [7:0]        r_data;

   logic              w_pick_vld;
   logic [W-1:0]      w_pick_idx;
   logic              w_hs;
   logic [7:0]        w_byte;
   logic [NUM_REQ-1:0] w_req_ready;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_vld),
      .o_idx   (w_pick_idx)
   );

   assign w_hs   = (r_state == S_LOAD) && req_valid[r_grant_id];
   assign w_byte = req_data[{r_grant_id, 3'b000} +: 8];

   // Ready is a pure decode of state and grant, so only the owner can ever be strobed.
   always_comb begin
      w_req_ready = '0;
      if (r_state == S_LOAD) w_req_ready[r_grant_id] = req_valid[r_grant_id];
   end

   // Arbitration and byte sequencing; the grant is held across a frame until its last byte drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ptr      <= W'(NUM_REQ - 1);
         r_grant_id <= '0;
         r_locked   <= 1'b0;
         r_data_en  <= 1'b0;
         r_data     <= 8'h00;
      end else begin
         r_data_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pick_vld) begin
                  r_grant_id <= w_pick_idx;
`ifdef UART_TX_ARB_ID_HDR_EN
                  r_state    <= S_HDR;
`else
                  r_state    <= S_LOAD;
`endif
               end
            end
`ifdef UART_TX_ARB_ID_HDR_EN
            S_HDR: begin
               // Header never handshakes with the client; the frame body always follows it.
               r_data    <= hdr_byte(4'(r_grant_id));
               r_data_en <= 1'b1;
               r_locked  <= 1'b1;
               r_state   <= S_WAIT_DONE;
            end
`endif
            S_LOAD: begin
               if (w_hs) begin
                  r_data    <= w_byte;
                  r_data_en <= 1'b1;
                  r_locked  <= !req_last[r_grant_id];
                  r_state   <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (u_tx_done) r_state <= S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
               // tx_done is multi-cycle; waiting for it to drop counts each byte once.
               if (!u_tx_done) begin
                  if (r_locked) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_ptr   <= r_grant_id;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = w_req_ready;
   assign u_data_en = r_data_en;
   assign u_data    = r_data;
   assign grant_id  = r_grant_id;
   assign busy      = (r_state != S_IDLE);

endmodule
